// File: rtl/sonic_echo_model.sv
// sonic_echo_model
//   Synthesizable stand-in for an ultrasonic ranging sensor (Trig/Echo far end).
//   Accepts a Trig pulse, waits a fixed burst delay, then drives an Echo pulse
//   whose width is distance_cm * US_PER_CM microseconds, or TIMEOUT_US when no
//   object is present or the distance is out of range.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous, active-high reset
//   trig         in   Trig from the measuring side, asynchronous to clk
//   distance_cm  in   programmed distance, sampled once per measurement
//   obj_present  in   1 = object present, 0 = force timeout echo
//   echo         out  Echo pulse to the measuring side
//   busy         out  high from Trig acceptance until the end of holdoff
//   trig_err     out  one-cycle pulse when an accepted Trig was too short
module sonic_echo_model #(
  parameter int unsigned TICKS_PER_US = 100,
  parameter int unsigned MIN_TRIG_US  = 10,
  parameter int unsigned BURST_US     = 200,
  parameter int unsigned US_PER_CM    = 58,
  parameter int unsigned MAX_CM       = 400,
  parameter int unsigned TIMEOUT_US   = 38000,
  parameter int unsigned HOLDOFF_US   = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [8:0] distance_cm,
  input  logic       obj_present,
  output logic       echo,
  output logic       busy,
  output logic       trig_err
);

  localparam int unsigned PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG_HI,
    S_BURST,
    S_ECHO,
    S_HOLDOFF
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic            r_sync1;
  logic            r_t_s;
  logic            r_t_d;
  logic            w_rise;
  logic            w_fall;

  logic [PW-1:0]   r_pre;
  logic            w_tick;
  logic [7:0]      r_hi_cnt;
  logic [15:0]     r_cnt;
  logic [15:0]     r_width;
  logic [15:0]     w_width_calc;
  logic [15:0]     w_target;
  logic            w_trig_ok;
  logic            w_short;
  logic            w_done;
  logic            w_entry;
  logic            w_in_range;
  logic            r_trig_err;

  assign w_rise = r_t_s & ~r_t_d;
  assign w_fall = ~r_t_s & r_t_d;
  assign w_tick = (r_pre == PW'(TICKS_PER_US - 1));

  // hi_cnt only advances at the end of a tick cycle, so a tick landing in the
  // fall-detect cycle is counted here; otherwise a Trig of exactly
  // MIN_TRIG_US would be rejected.
  assign w_trig_ok = (r_hi_cnt >= 8'(MIN_TRIG_US)) ||
                     (w_tick && (r_hi_cnt == 8'(MIN_TRIG_US - 1)));

  assign w_in_range   = obj_present && (distance_cm >= 9'd2) &&
                        (32'(distance_cm) <= MAX_CM);
  assign w_width_calc = w_in_range ? (16'(distance_cm) * 16'(US_PER_CM))
                                   : 16'(TIMEOUT_US);

  always_comb begin
    w_target = '0;
    case (r_state)
      S_BURST:   w_target = 16'(BURST_US - 1);
      S_ECHO:    w_target = r_width - 16'd1;
      S_HOLDOFF: w_target = 16'(HOLDOFF_US - 1);
      default:   w_target = '0;
    endcase
  end

  assign w_done = w_tick && (r_cnt == w_target);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_short = 1'b0;
    case (r_state)
      S_IDLE:    if (w_rise) w_next = S_TRIG_HI;
      S_TRIG_HI: begin
        if (w_fall) begin
          if (w_trig_ok) begin
            w_next = S_BURST;
          end else begin
            w_next  = S_IDLE;
            w_short = 1'b1;
          end
        end
      end
      S_BURST:   if (w_done) w_next = S_ECHO;
      S_ECHO:    if (w_done) w_next = S_HOLDOFF;
      S_HOLDOFF: if (w_done) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    w_entry = (w_next != r_state);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_t_s      <= 1'b0;
      r_t_d      <= 1'b0;
      r_pre      <= '0;
      r_hi_cnt   <= '0;
      r_cnt      <= '0;
      r_width    <= '0;
      r_trig_err <= 1'b0;
    end else begin
      r_sync1    <= trig;
      r_t_s      <= r_sync1;
      r_t_d      <= r_t_s;
      r_trig_err <= w_short;

      // Prescaler and counters restart on every state entry so each timed
      // interval is an exact multiple of TICKS_PER_US cycles.
      if (w_entry) begin
        r_pre    <= '0;
        r_cnt    <= '0;
        r_hi_cnt <= '0;
      end else if (r_state != S_IDLE) begin
        r_pre <= w_tick ? '0 : r_pre + PW'(1);
        if (w_tick) begin
          r_cnt <= r_cnt + 16'd1;
          if ((r_state == S_TRIG_HI) && (r_hi_cnt != 8'hFF)) begin
            r_hi_cnt <= r_hi_cnt + 8'd1;
          end
        end
      end

      if ((r_state == S_TRIG_HI) && w_fall && w_trig_ok) begin
        r_width <= w_width_calc;
      end
    end
  end

  assign echo     = (r_state == S_ECHO);
  assign busy     = (r_state != S_IDLE);
  assign trig_err = r_trig_err;

endmodule

// File: tb/tb_sonic_echo_model.sv
// tb_sonic_echo_model
//   Self-checking bench for sonic_echo_model using shortened timing parameters.
//   Table vectors carry hand-computed expectations; random transactions are
//   checked against a distance/width model written from the ranging rules.
module tb_sonic_echo_model;

  localparam int T    = 4;
  localparam int MINT = 10;
  localparam int BUR  = 20;
  localparam int UPC  = 3;
  localparam int MAXC = 40;
  localparam int TO   = 150;
  localparam int HOLD = 30;

  logic       clk;
  logic       rst;
  logic       trig;
  logic [8:0] distance_cm;
  logic       obj_present;
  logic       echo;
  logic       busy;
  logic       trig_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int n_rise = 0, n_err = 0;
  int rise_cyc = 0, fall_cyc = 0, brise_cyc = 0, bfall_cyc = 0;
  int err_cyc = 0, err_run = 0, err_len = 0;
  logic p_echo = 1'b0, p_busy = 1'b0, p_err = 1'b0;

  sonic_echo_model #(
    .TICKS_PER_US(T),
    .MIN_TRIG_US (MINT),
    .BURST_US    (BUR),
    .US_PER_CM   (UPC),
    .MAX_CM      (MAXC),
    .TIMEOUT_US  (TO),
    .HOLDOFF_US  (HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trig       (trig),
    .distance_cm(distance_cm),
    .obj_present(obj_present),
    .echo       (echo),
    .busy       (busy),
    .trig_err   (trig_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (echo && !p_echo) begin n_rise++; rise_cyc = cyc; end
    if (!echo && p_echo) fall_cyc = cyc;
    if (busy && !p_busy) brise_cyc = cyc;
    if (!busy && p_busy) bfall_cyc = cyc;
    if (trig_err && !p_err) begin n_err++; err_cyc = cyc; err_run = 1; end
    else if (trig_err) err_run++;
    if (!trig_err && p_err) err_len = err_run;
    p_echo = echo;
    p_busy = busy;
    p_err  = trig_err;
  end

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0d want=%0d", nm, idx, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int idx, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s[%0d] got=%0d want=%0d..%0d", nm, idx, act, lo, hi);
    end
  endtask

  task automatic wait_echo(input logic lvl, input int budget, input int idx);
    int n = 0;
    while (echo !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (echo !== lvl) begin
      total++;
      bad++;
      $display("FAIL wait_echo[%0d] got=%b want=%b (timeout)", idx, echo, lvl);
    end
  endtask

  task automatic wait_idle(input int budget, input int idx);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL wait_idle[%0d] got=%b want=0 (timeout)", idx, busy);
    end
  endtask

  task automatic pulse(input int hi_cyc);
    trig = 1'b1;
    repeat (hi_cyc) @(negedge clk);
    trig = 1'b0;
  endtask

  // mode: 0 plain, 1 change distance during echo, 2 extra Trig during echo,
  // 3 extra Trig during holdoff
  task automatic transact(input int hi_cyc, input int d, input bit obj, input int mode,
                          input bit exp_acc, input int exp_w, input int idx);
    int base_r, base_e, t_rise, t_fall;
    distance_cm = 9'(d);
    obj_present = obj;
    @(negedge clk);
    base_r = n_rise;
    base_e = n_err;
    t_rise = cyc;
    pulse(hi_cyc);
    t_fall = cyc;
    if (exp_acc && mode != 0) begin
      wait_echo(1'b1, 3000, idx);
      if (mode == 1) distance_cm = 9'd20;
      if (mode == 2) pulse(12 * T);
      if (mode == 3) begin
        wait_echo(1'b0, 3000, idx);
        pulse(12 * T);
      end
    end
    wait_idle(5000, idx);
    repeat (10) @(negedge clk);
    chk("idle_busy", idx, int'(busy), 0);
    chk("busy_rise", idx, brise_cyc - t_rise, 3);
    if (exp_acc) begin
      chk("n_echo", idx, n_rise - base_r, 1);
      chk("n_err", idx, n_err - base_e, 0);
      chk_rng("echo_lat", idx, rise_cyc - t_fall, 3 + BUR * T - 3, 3 + BUR * T + 3);
      chk("echo_width", idx, fall_cyc - rise_cyc, exp_w * T);
      chk("echo_us", idx, (fall_cyc - rise_cyc) / T, exp_w);
      chk("holdoff", idx, bfall_cyc - fall_cyc, HOLD * T);
    end else begin
      chk("n_echo", idx, n_rise - base_r, 0);
      chk("n_err", idx, n_err - base_e, 1);
      chk("err_len", idx, err_len, 1);
      chk_rng("err_lat", idx, err_cyc - t_fall, 2, 4);
    end
  endtask

  function automatic int model_width(input int d, input bit obj);
    if (obj && d >= 2 && d <= MAXC) return d * UPC;
    return TO;
  endfunction

  typedef struct {
    int hi_us;
    int d;
    bit obj;
    int mode;
    bit exp_acc;
    int exp_w;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{12, 10,  1'b1, 0, 1'b1, 30};
    tbl[1]  = '{5,  10,  1'b1, 0, 1'b0, 0};
    tbl[2]  = '{12, 10,  1'b1, 0, 1'b1, 30};
    tbl[3]  = '{12, 10,  1'b0, 0, 1'b1, 150};
    tbl[4]  = '{12, 450, 1'b1, 0, 1'b1, 150};
    tbl[5]  = '{12, 1,   1'b1, 0, 1'b1, 150};
    tbl[6]  = '{12, 2,   1'b1, 0, 1'b1, 6};
    tbl[7]  = '{12, 40,  1'b1, 1, 1'b1, 120};
    tbl[8]  = '{12, 41,  1'b1, 0, 1'b1, 150};
    tbl[9]  = '{10, 10,  1'b1, 0, 1'b1, 30};
    tbl[10] = '{9,  7,   1'b1, 0, 1'b0, 0};
    tbl[11] = '{12, 10,  1'b1, 2, 1'b1, 30};
    tbl[12] = '{12, 10,  1'b1, 3, 1'b1, 30};
    tbl[13] = '{12, 0,   1'b1, 0, 1'b1, 150};

    trig = 1'b0;
    distance_cm = 9'd10;
    obj_present = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_echo", 0, int'(echo), 0);
    chk("rst_busy", 0, int'(busy), 0);
    chk("rst_err", 0, int'(trig_err), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", 0, int'(busy), 0);

    for (int i = 0; i < 14; i++) begin
      transact(tbl[i].hi_us * T, tbl[i].d, tbl[i].obj, tbl[i].mode,
               tbl[i].exp_acc, tbl[i].exp_w, i);
    end

    // Reset in the middle of an echo pulse
    distance_cm = 9'd10;
    obj_present = 1'b1;
    pulse(12 * T);
    wait_echo(1'b1, 3000, 100);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_echo", 100, int'(echo), 0);
    chk("midrst_busy", 100, int'(busy), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("after_rst_busy", 100, int'(busy), 0);
    chk("after_rst_echo", 100, int'(echo), 0);
    transact(12 * T, 10, 1'b1, 0, 1'b1, 30, 101);

    // Random transactions against the ranging model
    for (int i = 0; i < 20; i++) begin
      int hc, d;
      bit ob;
      hc = int'($urandom_range(7 * T, 14 * T));
      if ($urandom_range(0, 9) == 0) d = int'($urandom_range(41, 511));
      else d = int'($urandom_range(0, 45));
      ob = ($urandom_range(0, 4) != 0);
      transact(hc, d, ob, 0, (hc / T) >= MINT, model_width(d, ob), 200 + i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
